// File: rtl/seg7_scan_io.sv
// Four-digit multiplexed 7-segment controller on the MicroBlaze MCS I/O bus.
// Software-owned digit/control/raw registers; hardware owns refresh and blanking.
module seg7_scan_io #(
  parameter logic [31:0] BASE_ADDR = 32'hC000_0010,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned GAP       = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IO_Address,
  input  logic        IO_Addr_Strobe,
  input  logic [3:0]  IO_Byte_Enable,
  input  logic [31:0] IO_Write_Data,
  input  logic        IO_Write_Strobe,
  input  logic        IO_Read_Strobe,
  output logic [31:0] IO_Read_Data,
  output logic        IO_Ready,
  output logic [7:0]  nSEG,
  output logic [3:0]  nAN
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GAP_CNT    = PW'(GAP);
  localparam logic [31:0] ADDR_DATA = BASE_ADDR;
  localparam logic [31:0] ADDR_CTRL = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_RAW  = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADDR_STAT = BASE_ADDR + 32'hC;

  logic [15:0]   r_data;
  logic [3:0]    r_dp;
  logic [3:0]    r_blank;
  logic          r_raw_mode;
  logic [31:0]   r_raw;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_digit;
  logic [15:0]   r_frames;
  logic [31:0]   r_rd_data;
  logic          r_ready;
  logic [7:0]    r_nseg;
  logic [3:0]    r_nan;

  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_wr_data;
  logic          w_wr_ctrl;
  logic          w_wr_raw;
  logic          w_wr_stat;
  logic          w_presc_tc;
  logic          w_wrap;
  logic [3:0]    w_nib;
  logic [7:0]    w_raw_byte;
  logic [7:0]    w_pattern;
  logic [3:0]    w_an_n;
  logic [31:0]   w_rd_val;

  // Active-high {g,f,e,d,c,b,a} for a hex nibble.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_wr_en    = IO_Addr_Strobe & IO_Write_Strobe;
  assign w_rd_en    = IO_Addr_Strobe & IO_Read_Strobe;
  assign w_wr_data  = w_wr_en & (IO_Address == ADDR_DATA);
  assign w_wr_ctrl  = w_wr_en & (IO_Address == ADDR_CTRL);
  assign w_wr_raw   = w_wr_en & (IO_Address == ADDR_RAW);
  assign w_wr_stat  = w_wr_en & (IO_Address == ADDR_STAT);
  assign w_presc_tc = (r_presc == PRESC_LAST);
  assign w_wrap     = w_presc_tc & (r_digit == 2'd3);

  // Segment pattern and anode enables for the digit currently being scanned.
  always_comb begin
    w_nib      = r_data[{r_digit, 2'b00} +: 4];
    w_raw_byte = r_raw[{r_digit, 3'b000} +: 8];
    if (r_blank[r_digit])
      w_pattern = 8'h00;
    else if (r_raw_mode)
      w_pattern = w_raw_byte;
    else
      w_pattern = {r_dp[r_digit], hex_seg(w_nib)};
    w_an_n = 4'hF;
    if ((r_presc >= GAP_CNT) && !r_blank[r_digit])
      w_an_n[r_digit] = 1'b0;
  end

  always_comb begin
    w_rd_val = 32'h0;
    case (IO_Address)
      ADDR_DATA: w_rd_val = {16'h0, r_data};
      ADDR_CTRL: w_rd_val = {23'h0, r_raw_mode, r_blank, r_dp};
      ADDR_RAW:  w_rd_val = r_raw;
      ADDR_STAT: w_rd_val = {r_frames, 14'h0, r_digit};
      default:   w_rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_data     <= '0;
      r_dp       <= '0;
      r_blank    <= '0;
      r_raw_mode <= 1'b0;
      r_raw      <= '0;
      r_presc    <= '0;
      r_digit    <= '0;
      r_frames   <= '0;
      r_rd_data  <= '0;
      r_ready    <= 1'b0;
      r_nseg     <= 8'hFF;
      r_nan      <= 4'hF;
    end else begin
      r_ready <= IO_Addr_Strobe & (IO_Write_Strobe | IO_Read_Strobe);
      if (w_rd_en)
        r_rd_data <= w_rd_val;

      if (w_wr_data) begin
        if (IO_Byte_Enable[0]) r_data[7:0]  <= IO_Write_Data[7:0];
        if (IO_Byte_Enable[1]) r_data[15:8] <= IO_Write_Data[15:8];
      end
      if (w_wr_ctrl) begin
        if (IO_Byte_Enable[0]) {r_blank, r_dp} <= IO_Write_Data[7:0];
        if (IO_Byte_Enable[1]) r_raw_mode      <= IO_Write_Data[8];
      end
      if (w_wr_raw) begin
        for (int b = 0; b < 4; b++)
          if (IO_Byte_Enable[b]) r_raw[8*b +: 8] <= IO_Write_Data[8*b +: 8];
      end

      if (w_presc_tc) begin
        r_presc <= '0;
        r_digit <= r_digit + 2'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      // A STATUS write beats a coincident frame wrap.
      if (w_wr_stat)
        r_frames <= '0;
      else if (w_wrap)
        r_frames <= r_frames + 16'd1;

      r_nseg <= ~w_pattern;
      r_nan  <= w_an_n;
    end
  end

  assign IO_Read_Data = r_rd_data;
  assign IO_Ready     = r_ready;
  assign nSEG         = r_nseg;
  assign nAN          = r_nan;

endmodule
